// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: NOP encoding, jump types, instruction field
// positions and the instruction-fetch state encoding.
package dlx_pkg;

  localparam logic [5:0]  NOP_OPCODE = 6'h00;
  localparam logic [5:0]  NOP_FUNCT  = 6'h15;
  localparam logic [31:0] NOP_INSTR  = {NOP_OPCODE, 20'h0_0000, NOP_FUNCT};

  typedef enum logic [1:0] {
    JT_NONE = 2'b00,
    JT_BR   = 2'b01,
    JT_J    = 2'b10,
    JT_JR   = 2'b11
  } jump_type_e;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_FULL  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  // Source of the next instruction register value.
  typedef enum logic [1:0] {
    IR_HOLD = 2'd0,
    IR_NOP  = 2'd1,
    IR_MEM  = 2'd2,
    IR_BUF  = 2'd3
  } ir_sel_e;

  // DLX numbers instruction bits from the MSB: inst[0] is bit 31 here.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS1_MSB    = 25;
  localparam int RS1_LSB    = 21;
  localparam int RS2_MSB    = 20;
  localparam int RS2_LSB    = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMMD_MSB   = 15;
  localparam int IMMD_LSB   = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sext26(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

endpackage

// File: rtl/ifetch_target.sv
// Redirect target computation for instruction fetch: PC-relative branch/jump
// adds (wrapping modulo 2^32) or the register-sourced jump target.
module ifetch_target
  import dlx_pkg::*;
(
  input  logic [1:0]  jump_type_i,
  input  logic [31:0] pc_plus_four_i,
  input  logic [15:0] immd_i,
  input  logic [25:0] joffset_i,
  input  logic [31:0] jreg_target_i,
  output logic [31:0] target_o
);

  always_comb begin
    target_o = jreg_target_i;
    case (jump_type_i)
      JT_BR:   target_o = pc_plus_four_i + sext16(immd_i);
      JT_J:    target_o = pc_plus_four_i + sext26(joffset_i);
      JT_JR:   target_o = jreg_target_i;
      default: target_o = jreg_target_i;
    endcase
  end

endmodule

// File: rtl/ifetch_stage.sv
// DLX instruction fetch stage: PC, single-outstanding imem port, registered
// instruction fields for Decode. Define IFETCH_PERF_EN to add perf counters.
module ifetch_stage
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  JumpType,
  input  logic        BranchCond,
  input  logic        BranchResult,
  input  logic [31:0] DecodePCPlusFour,
  input  logic [15:0] DecodeImmd,
  input  logic [25:0] DecodeJOffset,
  input  logic [31:0] JumpRegTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        IMemValid,
  output logic [5:0]  NextOpCode,
  output logic [4:0]  NextRs1,
  output logic [4:0]  NextRs2,
  output logic [4:0]  NextRd,
  output logic [15:0] NextImmd,
  output logic [5:0]  NextFunct,
`ifdef IFETCH_PERF_EN
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount,
  output logic [31:0] FlushCount,
`endif
  output logic [31:0] NextPCPlusFour
);

  if_state_e   state_q, state_d;
  ir_sel_e     ir_sel;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] bufpc_q, bufpc_d;
  logic [31:0] target;
  logic [31:0] pc_plus_four;
  logic        valid_acc;
  logic        redirect;

  ifetch_target u_target (
    .jump_type_i    (JumpType),
    .pc_plus_four_i (DecodePCPlusFour),
    .immd_i         (DecodeImmd),
    .joffset_i      (DecodeJOffset),
    .jreg_target_i  (JumpRegTarget),
    .target_o       (target)
  );

  // A valid pulse with no request outstanding is a protocol error; drop it.
  assign valid_acc    = IMemValid & req_q;
  assign pc_plus_four = pc_q + 32'd4;
  assign redirect     = !stall &
                        (((JumpType == JT_BR) && (BranchResult == BranchCond)) ||
                         (JumpType == JT_J) || (JumpType == JT_JR));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    buf_d   = buf_q;
    bufpc_d = bufpc_q;
    ir_sel  = IR_HOLD;

    case (state_q)
      IF_FETCH: begin
        if (redirect) begin
          pc_d   = target;
          ir_sel = IR_NOP;
          if (!valid_acc) state_d = IF_DROP;
        end else if (valid_acc) begin
          pc_d = pc_plus_four;
          if (stall) begin
            buf_d   = IMemData;
            bufpc_d = pc_plus_four;
            state_d = IF_FULL;
          end else begin
            ir_sel = IR_MEM;
            npc_d  = pc_plus_four;
          end
        end else if (!stall) begin
          ir_sel = IR_NOP;
        end
      end

      IF_FULL: begin
        if (redirect) begin
          pc_d    = target;
          ir_sel  = IR_NOP;
          state_d = IF_FETCH;
        end else if (!stall) begin
          ir_sel  = IR_BUF;
          npc_d   = bufpc_q;
          state_d = IF_FETCH;
        end
      end

      IF_DROP: begin
        // Waiting out the squashed request; the latest redirect target wins.
        if (redirect) begin
          pc_d   = target;
          ir_sel = IR_NOP;
        end else if (!stall) begin
          ir_sel = IR_NOP;
        end
        if (valid_acc) state_d = IF_FETCH;
      end

      default: begin
        state_d = IF_FETCH;
        ir_sel  = IR_NOP;
      end
    endcase

    case (ir_sel)
      IR_NOP:  ir_d = NOP_INSTR;
      IR_MEM:  ir_d = IMemData;
      IR_BUF:  ir_d = buf_q;
      default: ir_d = ir_q;
    endcase

    req_d  = (state_d != IF_FULL);
    addr_d = (state_d == IF_DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IF_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      ir_q    <= NOP_INSTR;
      npc_q   <= 32'h0;
      buf_q   <= 32'h0;
      bufpc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
      flush_cnt_q  <= 32'h0;
    end else begin
      if ((ir_sel == IR_MEM) || (ir_sel == IR_BUF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((ir_sel == IR_NOP) && !redirect)          bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (redirect)                                 flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
  assign FlushCount  = flush_cnt_q;
`endif

  assign IMemReq        = req_q;
  assign IMemAddr       = addr_q;
  assign NextOpCode     = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign NextRs1        = ir_q[RS1_MSB:RS1_LSB];
  assign NextRs2        = ir_q[RS2_MSB:RS2_LSB];
  assign NextRd         = ir_q[RD_MSB:RD_LSB];
  assign NextImmd       = ir_q[IMMD_MSB:IMMD_LSB];
  assign NextFunct      = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign NextPCPlusFour = npc_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed vector table, reset-in-DROP
// sequence, and randomized traffic against a behavioural fetch model.
module tb_ifetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0015;
  localparam logic [31:0] JNK = 32'hDEAD_BEEF;

  logic        clk, reset, stall;
  logic [1:0]  JumpType;
  logic        BranchCond, BranchResult;
  logic [31:0] DecodePCPlusFour;
  logic [15:0] DecodeImmd;
  logic [25:0] DecodeJOffset;
  logic [31:0] JumpRegTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemValid;
  logic [5:0]  NextOpCode;
  logic [4:0]  NextRs1, NextRs2, NextRd;
  logic [15:0] NextImmd;
  logic [5:0]  NextFunct;
  logic [31:0] NextPCPlusFour;
`ifdef IFETCH_PERF_EN
  logic [31:0] FetchCount, BubbleCount, FlushCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .JumpType         (JumpType),
    .BranchCond       (BranchCond),
    .BranchResult     (BranchResult),
    .DecodePCPlusFour (DecodePCPlusFour),
    .DecodeImmd       (DecodeImmd),
    .DecodeJOffset    (DecodeJOffset),
    .JumpRegTarget    (JumpRegTarget),
    .IMemReq          (IMemReq),
    .IMemAddr         (IMemAddr),
    .IMemData         (IMemData),
    .IMemValid        (IMemValid),
    .NextOpCode       (NextOpCode),
    .NextRs1          (NextRs1),
    .NextRs2          (NextRs2),
    .NextRd           (NextRd),
    .NextImmd         (NextImmd),
    .NextFunct        (NextFunct),
`ifdef IFETCH_PERF_EN
    .FetchCount       (FetchCount),
    .BubbleCount      (BubbleCount),
    .FlushCount       (FlushCount),
`endif
    .NextPCPlusFour   (NextPCPlusFour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  jt;
    logic        bc, br;
    logic [31:0] dpc;
    logic [15:0] immd;
    logic [25:0] joff;
    logic [31:0] jrt;
    logic        valid;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr, exp_ir, exp_npc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic [1:0] jt, logic bc, logic br, logic [31:0] dpc,
                              logic [15:0] immd, logic [25:0] joff, logic [31:0] jrt,
                              logic v, logic [31:0] d, logic er, logic [31:0] ea,
                              logic [31:0] ei, logic [31:0] en);
    vec_t r;
    r.stall = s; r.jt = jt; r.bc = bc; r.br = br; r.dpc = dpc; r.immd = immd;
    r.joff = joff; r.jrt = jrt; r.valid = v; r.data = d;
    r.exp_req = er; r.exp_addr = ea; r.exp_ir = ei; r.exp_npc = en;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_outs(input logic er, input logic [31:0] ea, input logic [31:0] ei,
                            input logic [31:0] en);
    chk("IMemReq", {31'h0, IMemReq}, {31'h0, er});
    chk("IMemAddr", IMemAddr, ea);
    chk("ir", {NextOpCode, NextRs1, NextRs2, NextImmd}, ei);
    chk("NextRd", {27'h0, NextRd}, {27'h0, ei[15:11]});
    chk("NextFunct", {26'h0, NextFunct}, {26'h0, ei[5:0]});
    chk("NextPCPlusFour", NextPCPlusFour, en);
  endtask

  task automatic drive(input logic s, input logic [1:0] jt, input logic bc, input logic br,
                       input logic [31:0] dpc, input logic [15:0] immd, input logic [25:0] joff,
                       input logic [31:0] jrt, input logic v, input logic [31:0] d);
    stall = s; JumpType = jt; BranchCond = bc; BranchResult = br;
    DecodePCPlusFour = dpc; DecodeImmd = immd; DecodeJOffset = joff;
    JumpRegTarget = jrt; IMemValid = v; IMemData = d;
  endtask

  // Behavioural model: a sequential fetcher with a one-entry skid slot and a
  // "discard the next response" flag, updated once per clock.
  logic [31:0] m_pc, m_addr, m_ir, m_npc, m_buf, m_bufpc;
  logic        m_req, m_have_buf, m_discard;

  task automatic model_reset();
    m_pc = 0; m_addr = 0; m_ir = NOP; m_npc = 0; m_buf = 0; m_bufpc = 0;
    m_req = 0; m_have_buf = 0; m_discard = 0;
  endtask

  task automatic model_step();
    logic        got;
    logic        taken;
    logic [31:0] tgt;
    got   = IMemValid && m_req;
    taken = !stall && ((JumpType == 2'b01 && BranchResult == BranchCond) || JumpType[1]);
    case (JumpType)
      2'b01:   tgt = DecodePCPlusFour + 32'($signed(DecodeImmd));
      2'b10:   tgt = DecodePCPlusFour + 32'($signed(DecodeJOffset));
      default: tgt = JumpRegTarget;
    endcase
    if (taken) begin
      m_ir = NOP;
      m_pc = tgt;
      if (m_have_buf) m_have_buf = 0;
      else if (m_discard) m_discard = !got;
      else m_discard = !got;
    end else if (m_have_buf) begin
      if (!stall) begin
        m_ir = m_buf; m_npc = m_bufpc; m_have_buf = 0;
      end
    end else if (m_discard) begin
      if (got) m_discard = 0;
      if (!stall) m_ir = NOP;
    end else if (got) begin
      if (stall) begin
        m_buf = IMemData; m_bufpc = m_pc + 4; m_have_buf = 1;
      end else begin
        m_ir = IMemData; m_npc = m_pc + 4;
      end
      m_pc = m_pc + 4;
    end else if (!stall) begin
      m_ir = NOP;
    end
    m_req = !m_have_buf;
    if (!m_discard) m_addr = m_pc;
  endtask

  initial begin
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outs(1'b0, 32'h0, NOP, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //          st jt   bc br dpc            immd     joff          jrt        v data           req addr        ir             npc
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     0, 32'h0,         1, 32'h0,      NOP,           32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     0, 32'h0,         1, 32'h0,      NOP,           32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     0, 32'h0,         1, 32'h0,      NOP,           32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     0, 32'h0,         1, 32'h0,      NOP,           32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h2001_0005, 1, 32'h4,      32'h2001_0005, 32'h4));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h2002_0006, 1, 32'h8,      32'h2002_0006, 32'h8));
    vecs.push_back(mk(1, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h8C41_0010, 0, 32'hC,      32'h2002_0006, 32'h8));
    vecs.push_back(mk(1, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, JNK,           0, 32'hC,      32'h2002_0006, 32'h8));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     0, 32'h0,         1, 32'hC,      32'h8C41_0010, 32'hC));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h0000_0020, 1, 32'h10,     32'h0000_0020, 32'h10));
    vecs.push_back(mk(0, 2'd1, 1, 1, 32'h40,        16'hFFF0, 26'h0,        32'h0,     0, 32'h0,         1, 32'h10,     NOP,           32'h10));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, JNK,           1, 32'h30,     NOP,           32'h10));
    vecs.push_back(mk(0, 2'd1, 1, 0, 32'h40,        16'hFFF0, 26'h0,        32'h0,     1, 32'h2003_0007, 1, 32'h34,     32'h2003_0007, 32'h34));
    vecs.push_back(mk(0, 2'd3, 0, 0, 32'h0,         16'h0,    26'h0,        32'h100,   0, 32'h0,         1, 32'h34,     NOP,           32'h34));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     0, 32'h0,         1, 32'h34,     NOP,           32'h34));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, JNK,           1, 32'h100,    NOP,           32'h34));
    vecs.push_back(mk(1, 2'd2, 0, 0, 32'h200,       16'h0,    26'h3FF_FFFC, 32'h0,     0, 32'h0,         1, 32'h100,    NOP,           32'h34));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h0C00_0003, 1, 32'h104,    32'h0C00_0003, 32'h104));
    vecs.push_back(mk(0, 2'd2, 0, 0, 32'h200,       16'h0,    26'h3FF_FFFC, 32'h0,     1, JNK,           1, 32'h1FC,    NOP,           32'h104));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h1234_5678, 1, 32'h200,    32'h1234_5678, 32'h200));
    vecs.push_back(mk(1, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h2004_0001, 0, 32'h204,    32'h1234_5678, 32'h200));
    vecs.push_back(mk(0, 2'd3, 0, 0, 32'h0,         16'h0,    26'h0,        32'h400,   0, 32'h0,         1, 32'h400,    NOP,           32'h200));
    vecs.push_back(mk(0, 2'd1, 0, 0, 32'hFFFF_FFF0, 16'h0020, 26'h0,        32'h0,     0, 32'h0,         1, 32'h400,    NOP,           32'h200));
    vecs.push_back(mk(0, 2'd3, 0, 0, 32'h0,         16'h0,    26'h0,        32'h500,   0, 32'h0,         1, 32'h400,    NOP,           32'h200));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, JNK,           1, 32'h500,    NOP,           32'h200));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h2001_0005, 1, 32'h504,    32'h2001_0005, 32'h504));
    vecs.push_back(mk(0, 2'd1, 0, 0, 32'hFFFF_FFF0, 16'h0020, 26'h0,        32'h0,     1, JNK,           1, 32'h10,     NOP,           32'h504));
    vecs.push_back(mk(0, 2'd0, 0, 0, 32'h0,         16'h0,    26'h0,        32'h0,     1, 32'h2001_0005, 1, 32'h14,     32'h2001_0005, 32'h14));

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].jt, vecs[i].bc, vecs[i].br, vecs[i].dpc, vecs[i].immd,
            vecs[i].joff, vecs[i].jrt, vecs[i].valid, vecs[i].data);
      @(posedge clk);
      #1 check_outs(vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_ir, vecs[i].exp_npc);
    end

    // Reset arriving while a squashed request is outstanding.
    drive(0, 2'b11, 0, 0, 0, 0, 0, 32'h700, 0, 0);
    @(posedge clk);
    #1 check_outs(1'b1, 32'h14, NOP, 32'h14);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check_outs(1'b0, 32'h0, NOP, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the behavioural model.
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [1:0] jt;
      jt = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
      drive(($urandom_range(0, 3) == 0), jt, 1'($urandom), 1'($urandom),
            {$urandom_range(0, 255), 2'b00}, 16'($urandom), 26'($urandom),
            {$urandom_range(0, 1023), 2'b00}, 1'($urandom), $urandom);
      model_step();
      @(posedge clk);
      #1 check_outs(m_req, m_addr, m_ir, m_npc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
